// File: rtl/rx_packet_checker.sv
// Receive-side packet checker for one switch output port: parses the header beat,
// verifies destination, payload length and payload pattern, and keeps statistics.
module rx_packet_checker #(
  parameter int RX_PORT         = 0,
  parameter int PORT_NUB_TOTAL  = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int PRIORITY        = 8,
  parameter int DATA_LENGTH_MAX = 256,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              rd_sop,
  input  logic                              rd_eop,
  input  logic                              rd_vld,
  input  logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              pkt_done,
  output logic                              pkt_ok,
  output logic [$clog2(PORT_NUB_TOTAL)-1:0] pkt_src,
  output logic [CNT_WIDTH-1:0]              pkt_cnt,
  output logic [PRIORITY*CNT_WIDTH-1:0]     pri_cnt,
  output logic [CNT_WIDTH-1:0]              err_cnt,
  output logic [4:0]                        err_sticky
);

  localparam int WS = $clog2(PORT_NUB_TOTAL);
  localparam int WP = $clog2(PRIORITY);
  localparam int WL = $clog2(DATA_LENGTH_MAX);
  localparam logic [WS-1:0] RX_SEL = WS'(RX_PORT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BODY      = 2'd1,
    HDR_CLOSE = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;

  logic [WS-1:0] dest_q, dest_d;
  logic [WP-1:0] pri_q, pri_d;
  logic [WL-1:0] len_q, len_d;
  logic [WS-1:0] src_q, src_d;
  logic [WL-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_data_q, err_data_d;
  logic          err_len_q, err_len_d;

  logic [WS-1:0] hdr_dest;
  logic [WP-1:0] hdr_pri;
  logic [WL-1:0] hdr_len;
  logic [WS-1:0] hdr_src;
  logic [DATA_WIDTH-1:0] exp_word;
  logic          beat_mis, beat_ovf, cnt_mis, start_pkt;

  // close event: err bits are {trunc, data, len, dest}
  logic          close_d;
  logic [3:0]    close_err_d;
  logic [WS-1:0] close_src_d;
  logic [WP-1:0] close_pri_d;
  logic          orphan_d;

  logic          pkt_done_q, pkt_ok_q, orphan_q;
  logic          pkt_ok_d;
  logic [WS-1:0] pkt_src_q, pkt_src_d;
  logic [3:0]    pkt_err_q;
  logic [WP-1:0] pkt_pri_q;

  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]           err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0] pri_cnt_q [PRIORITY];
  logic [CNT_WIDTH-1:0] pri_cnt_d [PRIORITY];
  logic                 pkt_bad;
  logic [1:0]           err_inc;

  assign hdr_dest = rd_data[WS-1:0];
  assign hdr_pri  = rd_data[WS+WP-1:WS];
  assign hdr_len  = rd_data[WS+WP+WL-1:WS+WP];
  assign hdr_src  = rd_data[WS+WP+WL+WS-1:WS+WP+WL];

  assign exp_word = DATA_WIDTH'({src_q, beat_cnt_q});
  assign beat_mis = (rd_data != exp_word);
  assign beat_ovf = (beat_cnt_q == {WL{1'b1}});
  assign cnt_mis  = (({1'b0, beat_cnt_q} + (WL+1)'(1)) != {1'b0, len_q});

  // Parse / close decision on the incoming beat
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    pri_d       = pri_q;
    len_d       = len_q;
    src_d       = src_q;
    beat_cnt_d  = beat_cnt_q;
    err_data_d  = err_data_q;
    err_len_d   = err_len_q;
    start_pkt   = 1'b0;
    close_d     = 1'b0;
    close_err_d = 4'b0000;
    close_src_d = src_q;
    close_pri_d = pri_q;
    orphan_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_vld) begin
          if (rd_sop && rd_eop) begin
            close_d     = 1'b1;
            close_err_d = {2'b00, hdr_len != '0, hdr_dest != RX_SEL};
            close_src_d = hdr_src;
            close_pri_d = hdr_pri;
          end else if (rd_sop) begin
            start_pkt = 1'b1;
            state_d   = BODY;
          end else begin
            orphan_d = 1'b1;
          end
        end
      end
      BODY: begin
        if (rd_vld) begin
          if (rd_sop) begin
            close_d     = 1'b1;
            close_err_d = {1'b1, err_data_q, err_len_q, dest_q != RX_SEL};
            start_pkt   = 1'b1;
            state_d     = rd_eop ? HDR_CLOSE : BODY;
          end else if (rd_eop) begin
            close_d     = 1'b1;
            close_err_d = {1'b0, err_data_q | beat_mis, err_len_q | beat_ovf | cnt_mis,
                           dest_q != RX_SEL};
            state_d     = IDLE;
          end else begin
            beat_cnt_d = beat_ovf ? beat_cnt_q : beat_cnt_q + WL'(1);
            err_data_d = err_data_q | beat_mis;
            err_len_d  = err_len_q | beat_ovf;
          end
        end
      end
      HDR_CLOSE: begin
        // header-only packet that arrived as a truncating sop closes here
        close_d     = 1'b1;
        close_err_d = {2'b00, len_q != '0, dest_q != RX_SEL};
        state_d     = IDLE;
        if (rd_vld) begin
          if (rd_sop) begin
            start_pkt = 1'b1;
            state_d   = rd_eop ? HDR_CLOSE : BODY;
          end else begin
            orphan_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_pkt) begin
      dest_d     = hdr_dest;
      pri_d      = hdr_pri;
      len_d      = hdr_len;
      src_d      = hdr_src;
      beat_cnt_d = '0;
      err_data_d = 1'b0;
      err_len_d  = 1'b0;
    end
  end

  assign pkt_ok_d  = close_d & ~|close_err_d;
  assign pkt_src_d = close_d ? close_src_d : pkt_src_q;

  // Statistics update from the registered close / orphan events
  assign pkt_bad = pkt_done_q & ~pkt_ok_q;
  assign err_inc = {1'b0, pkt_bad} + {1'b0, orphan_q};

  always_comb begin
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = sat_add(err_cnt_q, err_inc);
    err_sticky_d = err_sticky_q;
    for (int p = 0; p < PRIORITY; p++) pri_cnt_d[p] = pri_cnt_q[p];

    if (pkt_done_q && pkt_ok_q) begin
      pkt_cnt_d            = sat_add(pkt_cnt_q, 2'd1);
      pri_cnt_d[pkt_pri_q] = sat_add(pri_cnt_q[pkt_pri_q], 2'd1);
    end
    if (pkt_bad)  err_sticky_d = err_sticky_d | {1'b0, pkt_err_q};
    if (orphan_q) err_sticky_d = err_sticky_d | 5'b10000;

    if (clear) begin
      pkt_cnt_d    = '0;
      err_cnt_d    = '0;
      err_sticky_d = '0;
      for (int p = 0; p < PRIORITY; p++) pri_cnt_d[p] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pkt_done_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_src_q    <= '0;
      orphan_q     <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= '0;
      for (int p = 0; p < PRIORITY; p++) pri_cnt_q[p] <= '0;
    end else begin
      state_q      <= state_d;
      pkt_done_q   <= close_d;
      pkt_ok_q     <= pkt_ok_d;
      pkt_src_q    <= pkt_src_d;
      orphan_q     <= orphan_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      for (int p = 0; p < PRIORITY; p++) pri_cnt_q[p] <= pri_cnt_d[p];
    end
  end

  // Header and per-packet tracking state needs no reset
  always_ff @(posedge clk) begin
    dest_q     <= dest_d;
    pri_q      <= pri_d;
    len_q      <= len_d;
    src_q      <= src_d;
    beat_cnt_q <= beat_cnt_d;
    err_data_q <= err_data_d;
    err_len_q  <= err_len_d;
    pkt_err_q  <= close_err_d;
    pkt_pri_q  <= close_pri_d;
  end

  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_src    = pkt_src_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

  for (genvar g = 0; g < PRIORITY; g++) begin : g_pri_out
    assign pri_cnt[g*CNT_WIDTH +: CNT_WIDTH] = pri_cnt_q[g];
  end

endmodule

// File: tb/tb_rx_packet_checker.sv
// Directed and randomised-traffic bench for rx_packet_checker watching output port 2.
module tb_rx_packet_checker;

  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        rst, clear, rd_sop, rd_eop, rd_vld;
  logic [31:0] rd_data;
  logic        pkt_done, pkt_ok;
  logic [1:0]  pkt_src;
  logic [15:0] pkt_cnt, err_cnt;
  logic [127:0] pri_cnt;
  logic [4:0]  err_sticky;

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;
  int ok_seen = 0;

  rx_packet_checker #(
    .RX_PORT(2), .PORT_NUB_TOTAL(4), .DATA_WIDTH(32),
    .PRIORITY(8), .DATA_LENGTH_MAX(256), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_src(pkt_src),
    .pkt_cnt(pkt_cnt), .pri_cnt(pri_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_done) begin
      done_seen++;
      if (pkt_ok) ok_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int dest, input int pri, input int len, input int src);
    return 32'((src << 13) | (len << 5) | (pri << 2) | dest);
  endfunction

  function automatic logic [31:0] pl(input int src, input int k);
    return 32'((src << 8) | k);
  endfunction

  // Present one beat; returns 1ns after the edge that consumed it
  task automatic drive(input bit v, input bit s, input bit e, input logic [31:0] d);
    rd_vld = v; rd_sop = s; rd_eop = e; rd_data = d;
    @(posedge clk);
    #1;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0)
      drive(1'b0, 1'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic send_pkt(input int dest, input int pri, input int len, input int src,
                          input int nbeats, input int bad_k, input bit gaps);
    logic [31:0] d;
    maybe_gap(gaps);
    if (nbeats == 0) begin
      drive(1'b1, 1'b1, 1'b1, hdr(dest, pri, len, src));
    end else begin
      drive(1'b1, 1'b1, 1'b0, hdr(dest, pri, len, src));
      for (int k = 0; k < nbeats; k++) begin
        maybe_gap(gaps);
        d = pl(src, k);
        if (k == bad_k) d = d ^ 32'h1;
        drive(1'b1, 1'b0, (k == nbeats - 1), d);
      end
    end
  endtask

  int exp_pkt, exp_err, done0, ok0, n_after;
  int exp_pri [8];
  int dest, pri, len, src;

  initial begin
    rst = 1'b1; clear = 1'b0;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;

    // Reset state
    do_reset();
    chk("rst_done", pkt_done, 0);
    chk("rst_ok", pkt_ok, 0);
    chk("rst_src", pkt_src, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sticky", err_sticky, 0);

    // Good packet src=1 pri=1 len=16
    send_pkt(2, 1, 16, 1, 16, -1, 1'b0);
    chk("good_done", pkt_done, 1);
    chk("good_ok", pkt_ok, 1);
    chk("good_src", pkt_src, 1);
    idle(1);
    chk("good_done_pulse", pkt_done, 0);
    chk("good_pkt_cnt", pkt_cnt, 1);
    chk("good_pri1", pri_cnt[1*CW +: CW], 1);
    chk("good_pri0", pri_cnt[0*CW +: CW], 0);
    chk("good_err_cnt", err_cnt, 0);

    // Length 20 but only 19 beats
    do_reset();
    send_pkt(2, 0, 20, 1, 19, -1, 1'b0);
    chk("len_done", pkt_done, 1);
    chk("len_ok", pkt_ok, 0);
    idle(1);
    chk("len_sticky", err_sticky, 5'b00010);
    chk("len_err_cnt", err_cnt, 1);
    chk("len_pkt_cnt", pkt_cnt, 0);

    // Corrupted payload beat 5, then a clean packet
    do_reset();
    send_pkt(2, 0, 16, 1, 16, 5, 1'b0);
    chk("data_ok", pkt_ok, 0);
    idle(1);
    chk("data_sticky", err_sticky, 5'b00100);
    chk("data_err_cnt", err_cnt, 1);
    send_pkt(2, 2, 16, 3, 16, -1, 1'b0);
    chk("data_next_ok", pkt_ok, 1);
    chk("data_next_src", pkt_src, 3);
    idle(1);
    chk("data_next_pkt_cnt", pkt_cnt, 1);
    chk("data_next_pri2", pri_cnt[2*CW +: CW], 1);

    // sop at beat 8 of a len=16 packet, then a full good packet
    do_reset();
    drive(1'b1, 1'b1, 1'b0, hdr(2, 0, 16, 1));
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0, pl(1, k));
    drive(1'b1, 1'b1, 1'b0, hdr(2, 4, 16, 2));
    chk("trunc_done", pkt_done, 1);
    chk("trunc_ok", pkt_ok, 0);
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, (k == 15), pl(2, k));
    chk("trunc_next_done", pkt_done, 1);
    chk("trunc_next_ok", pkt_ok, 1);
    idle(1);
    chk("trunc_pkt_cnt", pkt_cnt, 1);
    chk("trunc_err_cnt", err_cnt, 1);
    chk("trunc_sticky", err_sticky, 5'b01000);

    // Truncating sop that is itself a header-only packet
    do_reset();
    drive(1'b1, 1'b1, 1'b0, hdr(2, 0, 4, 1));
    drive(1'b1, 1'b0, 1'b0, pl(1, 0));
    drive(1'b1, 1'b0, 1'b0, pl(1, 1));
    drive(1'b1, 1'b1, 1'b1, hdr(2, 5, 0, 3));
    chk("ho_trunc_done", pkt_done, 1);
    chk("ho_trunc_ok", pkt_ok, 0);
    chk("ho_trunc_src", pkt_src, 1);
    idle(1);
    chk("ho_next_done", pkt_done, 1);
    chk("ho_next_ok", pkt_ok, 1);
    chk("ho_next_src", pkt_src, 3);
    idle(1);
    chk("ho_done_pulse", pkt_done, 0);
    chk("ho_pkt_cnt", pkt_cnt, 1);
    chk("ho_pri5", pri_cnt[5*CW +: CW], 1);
    chk("ho_err_cnt", err_cnt, 1);

    // Orphan beats, then header-only len=0 packet
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, (i == 1), 32'h55 + i);
      chk("orph_no_done", pkt_done, 0);
    end
    idle(1);
    chk("orph_no_done_end", pkt_done, 0);
    chk("orph_err_cnt", err_cnt, 3);
    chk("orph_sticky", err_sticky, 5'b10000);
    chk("orph_pkt_cnt", pkt_cnt, 0);
    drive(1'b1, 1'b1, 1'b1, hdr(2, 3, 0, 2));
    chk("hdr_only_done", pkt_done, 1);
    chk("hdr_only_ok", pkt_ok, 1);
    chk("hdr_only_src", pkt_src, 2);
    idle(1);
    chk("hdr_only_pkt_cnt", pkt_cnt, 1);
    chk("hdr_only_pri3", pri_cnt[3*CW +: CW], 1);

    // Header-only with non-zero length is a length error
    do_reset();
    drive(1'b1, 1'b1, 1'b1, hdr(2, 0, 3, 0));
    chk("hdr_len_ok", pkt_ok, 0);
    idle(1);
    chk("hdr_len_sticky", err_sticky, 5'b00010);

    // Long random run with gaps, clear pulsed mid-way
    do_reset();
    exp_pkt = 0; exp_err = 0; n_after = 0;
    for (int p = 0; p < 8; p++) exp_pri[p] = 0;
    done0 = 0; ok0 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        idle(2);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clear_pkt_cnt", pkt_cnt, 0);
        chk("clear_err_cnt", err_cnt, 0);
        done0 = done_seen;
        ok0 = ok_seen;
      end
      dest = (i == 700) ? 3 : 2;
      pri  = $urandom_range(0, 7);
      len  = $urandom_range(0, 8);
      src  = $urandom_range(0, 3);
      send_pkt(dest, pri, len, src, len, -1, 1'b1);
      if (i >= 500) begin
        n_after++;
        if (dest == 2) begin
          exp_pkt++;
          exp_pri[pri]++;
        end else begin
          exp_err++;
        end
      end
    end
    idle(2);
    chk("rand_pkt_cnt", pkt_cnt, exp_pkt);
    chk("rand_err_cnt", err_cnt, exp_err);
    chk("rand_sticky", err_sticky, 5'b00001);
    chk("rand_done_count", done_seen - done0, n_after);
    chk("rand_ok_count", ok_seen - ok0, exp_pkt);
    for (int p = 0; p < 8; p++) chk($sformatf("rand_pri%0d", p), pri_cnt[p*CW +: CW], exp_pri[p]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
